// File: rtl/vga_pixel_transmitter.sv
// Pixel source for the VGA path: fetches frame-buffer pixels or generates test patterns,
// and delays the incoming sync/blank flags so they line up with the colour output.
module vga_pixel_transmitter #(
  parameter int unsigned WIDTH       = 640,
  parameter int unsigned HEIGHT      = 480,
  parameter int unsigned WIDTH_BITS  = 10,
  parameter int unsigned HEIGHT_BITS = 10,
  parameter int unsigned PIXEL_BITS  = 12,
  parameter int unsigned SCALE_SHIFT = 1,
  parameter int unsigned ADDR_BITS   = 17,
  parameter int unsigned RAM_LATENCY = 2
) (
  input  logic                   clock_in,
  input  logic                   reset_in,
  input  logic [WIDTH_BITS-1:0]  pixel_x_in,
  input  logic [HEIGHT_BITS-1:0] pixel_y_in,
  input  logic                   display_on_in,
  input  logic                   h_sync_in,
  input  logic                   v_sync_in,
  input  logic [1:0]             mode_in,
  input  logic [PIXEL_BITS-1:0]  solid_color_in,
  output logic [ADDR_BITS-1:0]   fb_addr_out,
  output logic                   fb_rd_out,
  input  logic [PIXEL_BITS-1:0]  fb_data_in,
  output logic [PIXEL_BITS-1:0]  pixel_out,
  output logic                   h_sync_out,
  output logic                   v_sync_out,
  output logic                   display_on_out,
  output logic [15:0]            frame_count_out,
  output logic                   frame_start_out
);

  localparam int unsigned Lat      = 1 + RAM_LATENCY;
  localparam int unsigned FbWidth  = WIDTH >> SCALE_SHIFT;
  localparam int unsigned BarWidth = WIDTH / 8;
  localparam int unsigned ChanBits = PIXEL_BITS / 3;

  typedef enum logic [1:0] {
    ModeFb    = 2'b00,
    ModeBars  = 2'b01,
    ModeSolid = 2'b10,
    ModeBlack = 2'b11
  } mode_e;

  // Pattern and solid colours are resolved at stage 0 and carried as one field.
  typedef struct packed {
    logic                  hs;
    logic                  vs;
    logic                  de;
    mode_e                 mode;
    logic [PIXEL_BITS-1:0] color;
  } stage_t;

  localparam stage_t StageReset = '{hs: 1'b1, vs: 1'b1, de: 1'b0, mode: ModeBlack, color: '0};

  // Frame boundary tracking
  mode_e       active_mode_q, active_mode_d;
  logic        vs_q, vs_d;
  logic        vs_armed_q, vs_armed_d;
  logic        frame_boundary;
  logic [15:0] frame_count_q, frame_count_d;
  logic        frame_start_q, frame_start_d;

  // The first cycle after reset only primes vs_q, so a low v_sync at release is not an edge.
  always_comb begin
    frame_boundary = vs_armed_q && vs_q && !v_sync_in;
    vs_d           = v_sync_in;
    vs_armed_d     = 1'b1;
    active_mode_d  = active_mode_q;
    frame_count_d  = frame_count_q;
    if (frame_boundary) begin
      active_mode_d = mode_e'(mode_in);
      frame_count_d = frame_count_q + 16'd1;
    end
    frame_start_d = frame_boundary;
  end

  always_ff @(posedge clock_in or posedge reset_in) begin
    if (reset_in) begin
      active_mode_q <= ModeBlack;
      vs_q          <= 1'b1;
      vs_armed_q    <= 1'b0;
      frame_count_q <= '0;
      frame_start_q <= 1'b0;
    end else begin
      active_mode_q <= active_mode_d;
      vs_q          <= vs_d;
      vs_armed_q    <= vs_armed_d;
      frame_count_q <= frame_count_d;
      frame_start_q <= frame_start_d;
    end
  end

  // Stage 0: address generation, pattern colour and pipeline entry
  logic [WIDTH_BITS-1:0]  fb_x;
  logic [HEIGHT_BITS-1:0] fb_y;
  logic [ADDR_BITS-1:0]   addr_calc;
  logic                   in_range;
  logic [2:0]             bar_idx;
  logic [PIXEL_BITS-1:0]  bar_color;
  logic [PIXEL_BITS-1:0]  stage0_color;
  logic [ADDR_BITS-1:0]   fb_addr_q, fb_addr_d;
  logic                   fb_rd_q, fb_rd_d;
  stage_t                 pipe_q [Lat];
  stage_t                 pipe_d [Lat];

  always_comb begin
    fb_x      = pixel_x_in >> SCALE_SHIFT;
    fb_y      = pixel_y_in >> SCALE_SHIFT;
    addr_calc = ADDR_BITS'(32'(fb_y) * FbWidth + 32'(fb_x));
    in_range  = (32'(pixel_x_in) < WIDTH) && (32'(pixel_y_in) < HEIGHT);

    bar_idx = '0;
    for (int unsigned i = 1; i < 8; i++) begin
      if (32'(pixel_x_in) >= i * BarWidth) bar_idx = 3'(i);
    end
    // Bar order FFF,FF0,0FF,0F0,F0F,F00,00F,000: R=~idx[1], G=~idx[2], B=~idx[0].
    bar_color = PIXEL_BITS'({{ChanBits{~bar_idx[1]}}, {ChanBits{~bar_idx[2]}},
                             {ChanBits{~bar_idx[0]}}});

    case (active_mode_q)
      ModeBars:  stage0_color = bar_color;
      ModeSolid: stage0_color = solid_color_in;
      default:   stage0_color = '0;
    endcase

    fb_rd_d   = display_on_in && in_range && (active_mode_q == ModeFb);
    fb_addr_d = fb_rd_d ? addr_calc : fb_addr_q;

    pipe_d[0].hs    = h_sync_in;
    pipe_d[0].vs    = v_sync_in;
    pipe_d[0].de    = display_on_in;
    pipe_d[0].mode  = active_mode_q;
    pipe_d[0].color = stage0_color;
    for (int i = 1; i < Lat; i++) begin
      pipe_d[i] = pipe_q[i-1];
    end
  end

  always_ff @(posedge clock_in or posedge reset_in) begin
    if (reset_in) begin
      fb_addr_q <= '0;
      fb_rd_q   <= 1'b0;
      for (int i = 0; i < Lat; i++) begin
        pipe_q[i] <= StageReset;
      end
    end else begin
      fb_addr_q <= fb_addr_d;
      fb_rd_q   <= fb_rd_d;
      for (int i = 0; i < Lat; i++) begin
        pipe_q[i] <= pipe_d[i];
      end
    end
  end

  // Output stage: RAM data arrives exactly as its request reaches the last stage.
  stage_t out_stage;
  assign out_stage = pipe_q[Lat-1];

  always_comb begin
    pixel_out = '0;
    if (out_stage.de) begin
      case (out_stage.mode)
        ModeFb:              pixel_out = fb_data_in;
        ModeBars, ModeSolid: pixel_out = out_stage.color;
        default:             pixel_out = '0;
      endcase
    end
  end

  assign h_sync_out      = out_stage.hs;
  assign v_sync_out      = out_stage.vs;
  assign display_on_out  = out_stage.de;
  assign fb_addr_out     = fb_addr_q;
  assign fb_rd_out       = fb_rd_q;
  assign frame_count_out = frame_count_q;
  assign frame_start_out = frame_start_q;

endmodule

// File: tb/tb_vga_pixel_transmitter.sv
// Bench for vga_pixel_transmitter: randomized frames against a behavioural model,
// expected outputs queued by the driver and checked by an independent monitor.
module tb_vga_pixel_transmitter;

  localparam int W  = 640;
  localparam int H  = 480;
  localparam int SS = 1;
  localparam int AB = 17;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [9:0]  px, py;
  logic        de_i, hs_i, vs_i;
  logic [1:0]  mode;
  logic [11:0] solid;
  logic [16:0] fb_addr_out;
  logic        fb_rd_out;
  logic [11:0] fb_data;
  logic [11:0] pixel_out;
  logic        h_sync_out, v_sync_out, display_on_out;
  logic [15:0] frame_count_out;
  logic        frame_start_out;

  always #5 clk = ~clk;

  vga_pixel_transmitter dut (
    .clock_in        (clk),
    .reset_in        (rst),
    .pixel_x_in      (px),
    .pixel_y_in      (py),
    .display_on_in   (de_i),
    .h_sync_in       (hs_i),
    .v_sync_in       (vs_i),
    .mode_in         (mode),
    .solid_color_in  (solid),
    .fb_addr_out     (fb_addr_out),
    .fb_rd_out       (fb_rd_out),
    .fb_data_in      (fb_data),
    .pixel_out       (pixel_out),
    .h_sync_out      (h_sync_out),
    .v_sync_out      (v_sync_out),
    .display_on_out  (display_on_out),
    .frame_count_out (frame_count_out),
    .frame_start_out (frame_start_out)
  );

  function automatic logic [11:0] ram_f(input int a);
    if (a == 965) return 12'hABC;
    return 12'((a * 37) ^ (a >> 4));
  endfunction

  // Frame buffer with two-cycle synchronous read
  logic [11:0] ram_s1, ram_s2;
  always @(posedge clk) begin
    ram_s1 <= ram_f(int'(fb_addr_out));
    ram_s2 <= ram_s1;
  end
  assign fb_data = ram_s2;

  typedef struct packed {
    logic [11:0] pix;
    logic        hs;
    logic        vs;
    logic        de;
  } exp_t;

  typedef struct {
    int x;
    int y;
  } xy_t;

  exp_t expq[$];
  xy_t  dq[$];
  int   checks = 0;
  int   failures = 0;

  logic [1:0] m_mode;
  int         nxt_fc, exp_fc, nxt_addr, exp_addr;
  bit         nxt_fs, exp_fs, nxt_rd, exp_rd;
  bit         first, prev_vs;
  bit         mon_en = 1'b0;

  task automatic check(input string name, input int got, input int exp_v);
    checks++;
    if (got !== exp_v) begin
      failures++;
      $display("FAIL %s got=%0h expected=%0h at %0t", name, got, exp_v, $time);
    end
  endtask

  function automatic int addr_of(input int x, input int y);
    return ((y >> SS) * (W >> SS) + (x >> SS)) % (1 << AB);
  endfunction

  function automatic logic [11:0] bar_of(input int x);
    logic [11:0] tbl [8];
    tbl = '{12'hFFF, 12'hFF0, 12'h0FF, 12'h0F0, 12'hF0F, 12'hF00, 12'h00F, 12'h000};
    return tbl[x / (W / 8)];
  endfunction

  task automatic model_reset();
    exp_t r;
    m_mode   = 2'b11;
    nxt_fs   = 0;
    nxt_fc   = 0;
    nxt_rd   = 0;
    nxt_addr = 0;
    first    = 1;
    prev_vs  = 1;
    expq.delete();
    r.pix = '0;
    r.hs  = 1'b1;
    r.vs  = 1'b1;
    r.de  = 1'b0;
    repeat (3) expq.push_back(r);
  endtask

  // Called just after a rising edge; drives one cycle and records what it should produce.
  task automatic drive(input int x, input int y, input bit de, input bit hs, input bit vs,
                       input logic [1:0] md, input logic [11:0] sc);
    exp_t e;
    int   a;
    exp_fs   = nxt_fs;
    exp_fc   = nxt_fc;
    exp_rd   = nxt_rd;
    exp_addr = nxt_addr;
    mon_en   = 1'b1;
    px    = 10'(x);
    py    = 10'(y);
    de_i  = de;
    hs_i  = hs;
    vs_i  = vs;
    mode  = md;
    solid = sc;
    a = addr_of(x, y);
    nxt_rd = de && (m_mode == 2'b00);
    if (nxt_rd) nxt_addr = a;
    e.hs = hs;
    e.vs = vs;
    e.de = de;
    if (!de) e.pix = '0;
    else begin
      case (m_mode)
        2'b00:   e.pix = ram_f(a);
        2'b01:   e.pix = bar_of(x);
        2'b10:   e.pix = sc;
        default: e.pix = '0;
      endcase
    end
    expq.push_back(e);
    if (!first && prev_vs && !vs) begin
      nxt_fs = 1;
      nxt_fc = (nxt_fc + 1) & 16'hFFFF;
      m_mode = md;
    end else begin
      nxt_fs = 0;
    end
    first   = 0;
    prev_vs = vs;
    @(posedge clk);
    #1;
  endtask

  task automatic vblank(input logic [1:0] md, input logic [11:0] sc);
    repeat (2) drive(700, 500, 0, 1, 1, md, sc);
    repeat (3) drive(700, 500, 0, 0, 0, md, sc);
    repeat (2) drive(700, 500, 0, 1, 1, md, sc);
  endtask

  // Directed pixels from dq first, then random ones with periodic h-blanking.
  task automatic visible(input logic [1:0] ma, input logic [1:0] mb, input int n,
                         input logic [11:0] sc);
    int  total;
    int  k;
    xy_t p;
    total = dq.size() + n;
    k = 0;
    while (dq.size() > 0) begin
      p = dq.pop_front();
      drive(p.x, p.y, 1, 1, 1, (k < total / 2) ? ma : mb, sc);
      k++;
    end
    for (int i = 0; i < n; i++) begin
      if (i % 16 == 15) begin
        repeat (3) drive(640 + int'($urandom_range(0, 150)), int'($urandom_range(0, 520)),
                         0, 0, 1, (k < total / 2) ? ma : mb, sc);
      end
      drive(int'($urandom_range(0, W - 1)), int'($urandom_range(0, H - 1)), 1, 1, 1,
            (k < total / 2) ? ma : mb, sc);
      k++;
    end
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_hs"}, 32'(h_sync_out), 1);
    check({tag, "_vs"}, 32'(v_sync_out), 1);
    check({tag, "_de"}, 32'(display_on_out), 0);
    check({tag, "_pix"}, 32'(pixel_out), 0);
    check({tag, "_addr"}, 32'(fb_addr_out), 0);
    check({tag, "_rd"}, 32'(fb_rd_out), 0);
    check({tag, "_fc"}, 32'(frame_count_out), 0);
    check({tag, "_fs"}, 32'(frame_start_out), 0);
  endtask

  exp_t me;
  always @(negedge clk) begin
    if (mon_en) begin
      check("frame_start", 32'(frame_start_out), exp_fs ? 1 : 0);
      check("frame_count", 32'(frame_count_out), exp_fc);
      check("fb_rd", 32'(fb_rd_out), exp_rd ? 1 : 0);
      check("fb_addr", 32'(fb_addr_out), exp_addr);
      if (expq.size() >= 4) begin
        me = expq.pop_front();
        check("pixel", 32'(pixel_out), 32'(me.pix));
        check("h_sync", 32'(h_sync_out), 32'(me.hs));
        check("v_sync", 32'(v_sync_out), 32'(me.vs));
        check("display_on", 32'(display_on_out), 32'(me.de));
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    px = '0; py = '0; de_i = 0; hs_i = 1; vs_i = 0; mode = 2'b00; solid = '0;
    repeat (2) @(posedge clk);
    #1;
    check_reset_values("reset");

    // Release with v_sync low: no boundary, output black for the rest of this frame
    model_reset();
    rst = 0;
    repeat (3) drive(700, 500, 0, 1, 0, 2'b00, 12'h000);
    dq.push_back('{x: 10, y: 6});
    dq.push_back('{x: 639, y: 479});
    visible(2'b00, 2'b00, 120, 12'h000);

    // Frame-buffer mode
    vblank(2'b00, 12'h000);
    dq.push_back('{x: 10, y: 6});
    dq.push_back('{x: 639, y: 479});
    dq.push_back('{x: 0, y: 0});
    visible(2'b00, 2'b00, 250, 12'h000);

    // Colour bars
    vblank(2'b01, 12'h000);
    for (int x = 0; x <= 80; x++) dq.push_back('{x: x, y: 3});
    dq.push_back('{x: 639, y: 100});
    visible(2'b01, 2'b01, 150, 12'h000);

    // Mode request changes mid-frame; takes effect only at the next boundary
    vblank(2'b00, 12'h0F0);
    visible(2'b00, 2'b10, 250, 12'h0F0);
    vblank(2'b10, 12'h0F0);
    visible(2'b10, 2'b10, 150, 12'h0F0);

    // Frame counter wrap
    force dut.frame_count_q = 16'hFFFF;
    #1;
    release dut.frame_count_q;
    nxt_fc = 16'hFFFF;
    exp_fc = 16'hFFFF;
    visible(2'b10, 2'b10, 20, 12'h0F0);
    vblank(2'b10, 12'h0F0);
    visible(2'b10, 2'b10, 40, 12'h0F0);

    // Asynchronous reset mid-line
    #2;
    mon_en = 1'b0;
    rst = 1;
    #1;
    check_reset_values("midreset");
    repeat (2) @(posedge clk);
    #1;
    model_reset();
    rst = 0;
    visible(2'b10, 2'b10, 80, 12'h0F0);
    vblank(2'b10, 12'h0F0);
    visible(2'b10, 2'b10, 80, 12'h0F0);
    repeat (3) drive(700, 500, 0, 1, 1, 2'b10, 12'h0F0);

    mon_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/vga_pixel_transmitter.md
Name: vga_pixel_transmitter

Overview:
- Pixel source end of the VGA pixel path. It is the transmitter counterpart of pixel_receiver.
- Consumes the vga_sync timing outputs, fetches pixels from a synchronous-read frame buffer, and outputs PIXEL_BITS colour with h_sync/v_sync/display_on delayed to match.
- Also generates colour-bar, solid and black patterns.
- Mode changes, frame counter and frame-start pulse are applied at frame boundaries.

Parameters:
- WIDTH, 640, visible pixels per line
- HEIGHT, 480, visible lines
- WIDTH_BITS, 10, pixel_x width
- HEIGHT_BITS, 10, pixel_y width
- PIXEL_BITS, 12, colour width, format {R[11:8],G[7:4],B[3:0]}
- SCALE_SHIFT, 1, frame buffer is (WIDTH>>SCALE_SHIFT) x (HEIGHT>>SCALE_SHIFT)
- ADDR_BITS, 17, frame buffer address width
- RAM_LATENCY, 2, cycles from fb_addr_out registered to fb_data_in valid (legal 1..4)

Ports:
- clock_in  in  1  pixel clock
- reset_in  in  1  asynchronous, active-high reset
- pixel_x_in  in  WIDTH_BITS  column from vga_sync
- pixel_y_in  in  HEIGHT_BITS  row from vga_sync
- display_on_in  in  1  visible-area flag from vga_sync
- h_sync_in  in  1  active-low horizontal sync
- v_sync_in  in  1  active-low vertical sync
- mode_in  in  2  requested mode: 00 frame buffer, 01 colour bars, 10 solid, 11 black
- solid_color_in  in  PIXEL_BITS  colour for mode 10
- fb_addr_out  out  ADDR_BITS  frame buffer read address (registered)
- fb_rd_out  out  1  read enable (registered)
- fb_data_in  in  PIXEL_BITS  read data, valid RAM_LATENCY cycles after address
- pixel_out  out  PIXEL_BITS  colour aligned with delayed syncs
- h_sync_out  out  1  h_sync_in delayed by L
- v_sync_out  out  1  v_sync_in delayed by L
- display_on_out  out  1  display_on_in delayed by L
- frame_count_out  out  16  completed-frame counter
- frame_start_out  out  1  one-cycle pulse at frame boundary

Behaviour:
- Latency: L = 1 + RAM_LATENCY cycles, identical for all modes. pixel_out and all delayed flags change together.
- Stage 0 registers inputs:
  - fb_addr_out = (pixel_y_in>>SCALE_SHIFT)*(WIDTH>>SCALE_SHIFT) + (pixel_x_in>>SCALE_SHIFT), truncated to ADDR_BITS. Constant multiply is allowed.
  - fb_rd_out = display_on_in && active_mode==00.
  - When fb_rd_out=0, fb_addr_out holds its previous value.
- Shift pipeline of depth L carries h_sync, v_sync, display_on, active_mode, pattern colour and solid colour. Stages 1..RAM_LATENCY wait for RAM data.
- Output stage:
  - Delayed display_on=0 -> pixel_out=0, regardless of mode.
  - Otherwise mode 00 -> fb_data_in; 01 -> bar colour; 10 -> solid_color_in sampled at stage 0; 11 -> 0.
- Colour bars: index = pixel_x_in / (WIDTH/8), 0..7. Colours in order: FFF, FF0, 0FF, 0F0, F0F, F00, 00F, 000.
- Frame boundary is the cycle after a falling edge of v_sync_in, detected from a registered copy. At the boundary:
  - active_mode <= mode_in.
  - frame_count_out increments, wrapping FFFF->0000.
  - frame_start_out=1 for exactly one cycle, undelayed.
- mode_in changes mid-frame have no effect until the next boundary.
- Reset (asynchronous, any time, including mid-frame):
  - All pipeline stages cleared.
  - h_sync_out=1, v_sync_out=1, display_on_out=0, pixel_out=0.
  - fb_addr_out=0, fb_rd_out=0, frame_count_out=0, frame_start_out=0.
  - active_mode=11 (black); v_sync edge detector preloaded to 1.
- Output stays black until the first frame boundary after reset.
- Release of reset while v_sync_in=0 must not produce a frame_start.
- Inputs x>=WIDTH or y>=HEIGHT only occur with display_on_in=0. No read is issued for them.

Test Plan:
- Reset released, mode_in=00 held, first frame runs -> pixel_out=0 and fb_rd_out=0 everywhere until the first v_sync fall; frame_start_out pulses once; frame_count_out=1.
- Mode 00, SCALE_SHIFT=1, RAM_LATENCY=2, input (x=10,y=6) visible -> fb_addr_out=965 one cycle later. Model RAM returns 0xABC -> pixel_out=0xABC exactly 3 cycles after the input, with display_on_out=1 in that cycle.
- Mode 00, pixel (639,479) -> fb_addr_out=76799. Pixel (0,0) -> 0. h_sync_out/v_sync_out equal the inputs shifted 3 cycles over a whole frame.
- Mode 01 -> pixel_out=0xFFF for x=0..79, 0xFF0 at x=80, 0x000 at x=639, and 0 during blanking.
- mode_in changed 00->10 (solid_color_in=0x0F0) mid-frame -> output unchanged until the next boundary, then 0x0F0 on all visible pixels. frame_count preloaded to 0xFFFF via 65535 frames or a force -> wraps to 0.
- reset_in pulsed mid-line while visible -> outputs go to reset values asynchronously (within the same cycle). After release, black output until the next v_sync fall.
